// File: rtl/pwm_pkg.sv
// Shared constants and state encoding for the PWM capture block.
package pwm_pkg;
  localparam int CNT_W_DEF    = 8;
  localparam int FILT_LEN_DEF = 3;
  localparam int CNT_MAX      = (1 << CNT_W_DEF) - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;
endpackage

// File: rtl/pwm_in_sync.sv
// PWM pad input conditioning: 2-flop synchronizer, optional glitch filter
// (PWM_CAPTURE_FILTER_EN) and rise/fall edge detect on the resulting level.
module pwm_in_sync #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pwm_in,
  output logic rise,
  output logic fall,
  output logic level
);
  logic [1:0] sync_q, sync_d;
  logic       lvl_dly_q, lvl_dly_d;
  logic       s;

  if (FILT_LEN < 2) begin : g_filt_len_chk
    $error("pwm_in_sync: FILT_LEN must be at least 2");
  end

  assign sync_d = {sync_q[0], pwm_in};
  assign s      = sync_q[1];

`ifdef PWM_CAPTURE_FILTER_EN
  // Level changes only once FILT_LEN consecutive samples agree; the window
  // includes the current sample, so the extra latency is FILT_LEN-1.
  logic [FILT_LEN-2:0] hist_q, hist_d;
  logic [FILT_LEN-1:0] win;
  logic                flt_q, flt_d;

  always_comb begin
    win    = {hist_q, s};
    hist_d = win[FILT_LEN-2:0];
    level  = (&win || ~|win) ? s : flt_q;
    flt_d  = level;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      flt_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      flt_q  <= flt_d;
    end
  end
`else
  assign level = s;
`endif

  assign lvl_dly_d = level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= 2'b00;
      lvl_dly_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      lvl_dly_q <= lvl_dly_d;
    end
  end

  assign rise = level & ~lvl_dly_q;
  assign fall = ~level & lvl_dly_q;
endmodule

// File: rtl/pwm_capture.sv
// Measures high time and rise-to-rise period of an external PWM line.
// Optional glitch filter in the input path: define PWM_CAPTURE_FILTER_EN.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int FILT_LEN = FILT_LEN_DEF
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             PWM_IN,
  output logic [CNT_W-1:0] HIGH_CNT,
  output logic [CNT_W-1:0] PERIOD_CNT,
  output logic             VALID,
  output logic             TIMEOUT
);
  localparam logic [CNT_W-1:0] MAX_V = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic rise, fall;
  logic sync_level_unused;

  pwm_in_sync #(.FILT_LEN(FILT_LEN)) u_in_sync (
    .clk    (CLK),
    .rst_n  (RST_N),
    .pwm_in (PWM_IN),
    .rise   (rise),
    .fall   (fall),
    .level  (sync_level_unused)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] hi_q, hi_d, per_q, per_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d, period_cnt_q, period_cnt_d;
  logic             valid_q, valid_d, timeout_q, timeout_d;

  always_comb begin
    state_d      = state_q;
    hi_d         = hi_q;
    per_d        = per_q;
    high_cnt_d   = high_cnt_q;
    period_cnt_d = period_cnt_q;
    valid_d      = 1'b0;
    timeout_d    = timeout_q;
    case (state_q)
      IDLE: begin
        if (rise) begin
          hi_d    = ONE;
          per_d   = ONE;
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (per_q == MAX_V) begin
          state_d   = IDLE;
          hi_d      = '0;
          per_d     = '0;
          timeout_d = 1'b1;
        end else begin
          per_d = per_q + ONE;
          if (fall) state_d = LOW;
          else      hi_d    = hi_q + ONE;
        end
      end
      LOW: begin
        // A rise on the last countable cycle still closes the period.
        if (rise) begin
          high_cnt_d   = hi_q;
          period_cnt_d = per_q;
          valid_d      = 1'b1;
          timeout_d    = 1'b0;
          hi_d         = ONE;
          per_d        = ONE;
          state_d      = HIGH;
        end else if (per_q == MAX_V) begin
          state_d   = IDLE;
          hi_d      = '0;
          per_d     = '0;
          timeout_d = 1'b1;
        end else begin
          per_d = per_q + ONE;
        end
      end
      default: begin
        state_d = IDLE;
        hi_d    = '0;
        per_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      hi_q         <= '0;
      per_q        <= '0;
      high_cnt_q   <= '0;
      period_cnt_q <= '0;
      valid_q      <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hi_q         <= hi_d;
      per_q        <= per_d;
      high_cnt_q   <= high_cnt_d;
      period_cnt_q <= period_cnt_d;
      valid_q      <= valid_d;
      timeout_q    <= timeout_d;
    end
  end

  assign HIGH_CNT   = high_cnt_q;
  assign PERIOD_CNT = period_cnt_q;
  assign VALID      = valid_q;
  assign TIMEOUT    = timeout_q;
endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: per-cycle PWM samples are scored
// against a rise/fall-index model of the measurement rules.
module tb_pwm_capture;
  localparam int CNT_W    = 8;
  localparam int FILT_LEN = 3;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;
`ifdef PWM_CAPTURE_FILTER_EN
  localparam int MINP = FILT_LEN;
`else
  localparam int MINP = 1;
`endif

  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic             PWM_IN = 1'b0;
  logic [CNT_W-1:0] HIGH_CNT, PERIOD_CNT;
  logic             VALID, TIMEOUT;

  int checks = 0;
  int errors = 0;

  bit xs[$];
  int mon_h[$], mon_p[$];
  int dbl_v;
  bit prev_v;
  int exp_h[$], exp_p[$];
  bit exp_to;
  int exp_hc, exp_pc;

  always #5 CLK = ~CLK;

  pwm_capture #(.CNT_W(CNT_W), .FILT_LEN(FILT_LEN)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .PWM_IN     (PWM_IN),
    .HIGH_CNT   (HIGH_CNT),
    .PERIOD_CNT (PERIOD_CNT),
    .VALID      (VALID),
    .TIMEOUT    (TIMEOUT)
  );

  always @(negedge CLK) begin
    if (RST_N) begin
      if (VALID) begin
        mon_h.push_back(int'(HIGH_CNT));
        mon_p.push_back(int'(PERIOD_CNT));
        if (prev_v) dbl_v++;
      end
      prev_v = VALID;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    mon_h.delete();
    mon_p.delete();
    dbl_v  = 0;
    prev_v = 1'b0;
  endtask

  task automatic do_reset();
    PWM_IN = 1'b0;
    RST_N  = 1'b0;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    xs.delete();
    xs.push_back(PWM_IN);
    clear_mon();
  endtask

  task automatic drive(bit v);
    @(negedge CLK);
    PWM_IN = v;
    xs.push_back(v);
  endtask

  task automatic phase(bit v, int n);
    repeat (n) drive(v);
  endtask

  task automatic wave(int h, int l, int n);
    repeat (n) begin
      phase(1'b1, h);
      phase(1'b0, l);
    end
  endtask

  task automatic flush();
    phase(PWM_IN, 10);
  endtask

  // Period = distance between accepted rises, high = first fall minus rise;
  // a gap beyond CNT_MAX abandons the measurement and raises the timeout.
  task automatic model();
    bit f[$];
    int start, fall_i;
    bit prev, cur;
    f = xs;
`ifdef PWM_CAPTURE_FILTER_EN
    for (int i = 0; i < xs.size(); i++) begin
      bit eq;
      eq = (i >= FILT_LEN - 1);
      for (int k = 1; k < FILT_LEN && eq; k++)
        if (xs[i-k] != xs[i]) eq = 1'b0;
      f[i] = eq ? xs[i] : ((i > 0) ? f[i-1] : 1'b0);
    end
`endif
    exp_h.delete();
    exp_p.delete();
    exp_to = 1'b0;
    exp_hc = 0;
    exp_pc = 0;
    start  = -1;
    fall_i = -1;
    prev   = 1'b0;
    for (int i = 0; i < f.size(); i++) begin
      cur = f[i];
      if (start >= 0 && i - start > CNT_MAX) begin
        exp_to = 1'b1;
        start  = -1;
      end
      if (!cur && prev && start >= 0 && fall_i < 0) fall_i = i;
      if (cur && !prev) begin
        if (start >= 0) begin
          exp_h.push_back(fall_i - start);
          exp_p.push_back(i - start);
          exp_hc = fall_i - start;
          exp_pc = i - start;
          exp_to = 1'b0;
        end
        start  = i;
        fall_i = -1;
      end
      prev = cur;
    end
    if (start >= 0 && f.size() - start > CNT_MAX) exp_to = 1'b1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if (HIGH_CNT !== 0 || PERIOD_CNT !== 0 || VALID !== 1'b0 || TIMEOUT !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got hc=%0d pc=%0d v=%b to=%b exp all 0", HIGH_CNT, PERIOD_CNT, VALID, TIMEOUT);
    end
    do_reset();
    phase(1'b0, 20);
    checks++;
    if (mon_h.size() != 0 || TIMEOUT !== 1'b0) begin
      errors++;
      $display("FAIL reset_quiet got valids=%0d to=%b exp 0 0", mon_h.size(), TIMEOUT);
    end
  endtask

  task automatic test_square();
    do_reset();
    phase(1'b0, 4);
    wave(3, 3, 8);
    flush();
    model();
    checks++;
    if (mon_h.size() != exp_h.size()) begin
      errors++;
      $display("FAIL square_count got %0d exp %0d", mon_h.size(), exp_h.size());
    end
    for (int i = 0; i < exp_h.size() && i < mon_h.size(); i++) begin
      checks++;
      if (mon_h[i] !== exp_h[i] || mon_p[i] !== exp_p[i]) begin
        errors++;
        $display("FAIL square_val[%0d] got (%0d,%0d) exp (%0d,%0d)", i, mon_h[i], mon_p[i], exp_h[i], exp_p[i]);
      end
    end
    checks++;
    if (mon_h.size() == 0 || mon_h[0] !== 3 || mon_p[0] !== 6) begin
      errors++;
      $display("FAIL square_first got %0d valids exp first (3,6)", mon_h.size());
    end
    checks++;
    if (HIGH_CNT !== exp_hc || PERIOD_CNT !== exp_pc || TIMEOUT !== exp_to || dbl_v != 0) begin
      errors++;
      $display("FAIL square_final got (%0d,%0d,%b,%0d) exp (%0d,%0d,%b,0)", HIGH_CNT, PERIOD_CNT, TIMEOUT, dbl_v, exp_hc, exp_pc, exp_to);
    end
  endtask

  task automatic test_duty_change();
    do_reset();
    phase(1'b0, 3);
    wave(2, 4, 5);
    wave(5, 3, 5);
    flush();
    model();
    checks++;
    if (mon_h.size() != exp_h.size()) begin
      errors++;
      $display("FAIL duty_count got %0d exp %0d", mon_h.size(), exp_h.size());
    end
    for (int i = 0; i < exp_h.size() && i < mon_h.size(); i++) begin
      checks++;
      if (mon_h[i] !== exp_h[i] || mon_p[i] !== exp_p[i]) begin
        errors++;
        $display("FAIL duty_val[%0d] got (%0d,%0d) exp (%0d,%0d)", i, mon_h[i], mon_p[i], exp_h[i], exp_p[i]);
      end
    end
    checks++;
    if (HIGH_CNT !== 5 || PERIOD_CNT !== 8 || dbl_v != 0) begin
      errors++;
      $display("FAIL duty_final got (%0d,%0d) dbl=%0d exp (5,8) dbl=0", HIGH_CNT, PERIOD_CNT, dbl_v);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    phase(1'b0, 3);
    wave(3, 3, 3);
    phase(1'b1, 300);
    model();
    checks++;
    if (TIMEOUT !== exp_to || HIGH_CNT !== 3 || PERIOD_CNT !== 6) begin
      errors++;
      $display("FAIL timeout_stuck got (%0d,%0d,to=%b) exp (3,6,to=%b)", HIGH_CNT, PERIOD_CNT, TIMEOUT, exp_to);
    end
    phase(1'b0, 4);
    wave(4, 4, 2);
    flush();
    model();
    checks++;
    if (mon_h.size() != exp_h.size()) begin
      errors++;
      $display("FAIL timeout_count got %0d exp %0d", mon_h.size(), exp_h.size());
    end
    for (int i = 0; i < exp_h.size() && i < mon_h.size(); i++) begin
      checks++;
      if (mon_h[i] !== exp_h[i] || mon_p[i] !== exp_p[i]) begin
        errors++;
        $display("FAIL timeout_val[%0d] got (%0d,%0d) exp (%0d,%0d)", i, mon_h[i], mon_p[i], exp_h[i], exp_p[i]);
      end
    end
    checks++;
    if (TIMEOUT !== exp_to || HIGH_CNT !== exp_hc || PERIOD_CNT !== exp_pc) begin
      errors++;
      $display("FAIL timeout_recover got (%0d,%0d,to=%b) exp (%0d,%0d,to=%b)", HIGH_CNT, PERIOD_CNT, TIMEOUT, exp_hc, exp_pc, exp_to);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    phase(1'b0, 3);
    wave(3, 3, 3);
    phase(1'b1, 2);
    checks++;
    if (HIGH_CNT !== 3 || PERIOD_CNT !== 6) begin
      errors++;
      $display("FAIL rstmid_pre got (%0d,%0d) exp (3,6)", HIGH_CNT, PERIOD_CNT);
    end
    @(negedge CLK);
    #2;
    RST_N  = 1'b0;
    PWM_IN = 1'b0;
    #1;
    checks++;
    if (HIGH_CNT !== 0 || PERIOD_CNT !== 0 || VALID !== 1'b0 || TIMEOUT !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async got (%0d,%0d,v=%b,to=%b) exp all 0", HIGH_CNT, PERIOD_CNT, VALID, TIMEOUT);
    end
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    xs.delete();
    xs.push_back(PWM_IN);
    clear_mon();
    phase(1'b0, 2);
    wave(3, 3, 3);
    flush();
    model();
    checks++;
    if (mon_h.size() != exp_h.size()) begin
      errors++;
      $display("FAIL rstmid_count got %0d exp %0d", mon_h.size(), exp_h.size());
    end
    for (int i = 0; i < exp_h.size() && i < mon_h.size(); i++) begin
      checks++;
      if (mon_h[i] !== exp_h[i] || mon_p[i] !== exp_p[i]) begin
        errors++;
        $display("FAIL rstmid_val[%0d] got (%0d,%0d) exp (%0d,%0d)", i, mon_h[i], mon_p[i], exp_h[i], exp_p[i]);
      end
    end
  endtask

`ifndef PWM_CAPTURE_FILTER_EN
  task automatic test_min_period();
    do_reset();
    phase(1'b0, 2);
    wave(1, 1, 20);
    flush();
    model();
    checks++;
    if (mon_h.size() != exp_h.size()) begin
      errors++;
      $display("FAIL minper_count got %0d exp %0d", mon_h.size(), exp_h.size());
    end
    for (int i = 0; i < exp_h.size() && i < mon_h.size(); i++) begin
      checks++;
      if (mon_h[i] !== exp_h[i] || mon_p[i] !== exp_p[i]) begin
        errors++;
        $display("FAIL minper_val[%0d] got (%0d,%0d) exp (%0d,%0d)", i, mon_h[i], mon_p[i], exp_h[i], exp_p[i]);
      end
    end
    checks++;
    if (dbl_v != 0) begin
      errors++;
      $display("FAIL minper_dbl_valid got %0d exp 0", dbl_v);
    end
  endtask
`endif

  task automatic test_boundary();
    do_reset();
    phase(1'b0, 3);
    phase(1'b1, 100);
    phase(1'b0, 155);
    phase(1'b1, 100);
    phase(1'b0, 156);
    wave(5, 5, 2);
    flush();
    model();
    checks++;
    if (mon_h.size() != exp_h.size()) begin
      errors++;
      $display("FAIL bound_count got %0d exp %0d", mon_h.size(), exp_h.size());
    end
    for (int i = 0; i < exp_h.size() && i < mon_h.size(); i++) begin
      checks++;
      if (mon_h[i] !== exp_h[i] || mon_p[i] !== exp_p[i]) begin
        errors++;
        $display("FAIL bound_val[%0d] got (%0d,%0d) exp (%0d,%0d)", i, mon_h[i], mon_p[i], exp_h[i], exp_p[i]);
      end
    end
    checks++;
    if (mon_p.size() == 0 || mon_p[0] !== CNT_MAX || TIMEOUT !== exp_to) begin
      errors++;
      $display("FAIL bound_max got n=%0d to=%b exp first period %0d to=%b", mon_p.size(), TIMEOUT, CNT_MAX, exp_to);
    end
  endtask

  task automatic test_random();
    do_reset();
    phase(1'b0, 3);
    repeat (30) wave(int'($urandom_range(24, MINP)), int'($urandom_range(24, MINP)), 1);
    flush();
    model();
    checks++;
    if (mon_h.size() != exp_h.size()) begin
      errors++;
      $display("FAIL rand_count got %0d exp %0d", mon_h.size(), exp_h.size());
    end
    for (int i = 0; i < exp_h.size() && i < mon_h.size(); i++) begin
      checks++;
      if (mon_h[i] !== exp_h[i] || mon_p[i] !== exp_p[i]) begin
        errors++;
        $display("FAIL rand_val[%0d] got (%0d,%0d) exp (%0d,%0d)", i, mon_h[i], mon_p[i], exp_h[i], exp_p[i]);
      end
    end
    checks++;
    if (HIGH_CNT !== exp_hc || PERIOD_CNT !== exp_pc || TIMEOUT !== exp_to || dbl_v != 0) begin
      errors++;
      $display("FAIL rand_final got (%0d,%0d,%b) exp (%0d,%0d,%b)", HIGH_CNT, PERIOD_CNT, TIMEOUT, exp_hc, exp_pc, exp_to);
    end
  endtask

  task automatic test_glitch();
    bit short_seen;
    do_reset();
    phase(1'b0, 4);
    wave(4, 4, 2);
    phase(1'b1, 4);
    phase(1'b0, 1);
    phase(1'b1, 2);
    phase(1'b0, 1);
    wave(4, 4, 2);
    flush();
    model();
    checks++;
    if (mon_h.size() != exp_h.size()) begin
      errors++;
      $display("FAIL glitch_count got %0d exp %0d", mon_h.size(), exp_h.size());
    end
    for (int i = 0; i < exp_h.size() && i < mon_h.size(); i++) begin
      checks++;
      if (mon_h[i] !== exp_h[i] || mon_p[i] !== exp_p[i]) begin
        errors++;
        $display("FAIL glitch_val[%0d] got (%0d,%0d) exp (%0d,%0d)", i, mon_h[i], mon_p[i], exp_h[i], exp_p[i]);
      end
    end
    short_seen = 1'b0;
    foreach (mon_p[i]) if (mon_p[i] < 8) short_seen = 1'b1;
    checks++;
`ifdef PWM_CAPTURE_FILTER_EN
    if (short_seen || mon_h.size() == 0) begin
      errors++;
      $display("FAIL glitch_filtered got short=%b n=%0d exp short=0 n>0", short_seen, mon_h.size());
    end
`else
    if (!short_seen) begin
      errors++;
      $display("FAIL glitch_unfiltered got short=%b exp short=1", short_seen);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_square();
    test_duty_change();
    test_timeout();
    test_reset_mid();
`ifndef PWM_CAPTURE_FILTER_EN
    test_min_period();
`endif
    test_boundary();
    test_random();
    test_glitch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
